// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin arbiter sharing one memory port between instruction fetch and data master
// One transaction in flight; aborts with err after TIMEOUT_CYCLES busy cycles without mem_ack.
module memory_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_req,
   input  logic [31:0] instr_addr,
   output logic        instr_ack,
   output logic [31:0] instr_data,
   output logic        instr_err,
   input  logic        data_cyc,
   input  logic        data_stb,
   input  logic        data_wr_en,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wr_data,
   input  logic [3:0]  data_wr_sel,
   output logic        data_ack,
   output logic        data_err,
   output logic        data_stall,
   output logic [31:0] data_rd_data,
   output logic        mem_cyc,
   output logic        mem_stb,
   output logic        mem_wr_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wr_data,
   output logic [3:0]  mem_wr_sel,
   input  logic        mem_ack,
   input  logic        mem_stall,
   input  logic [31:0] mem_rd_data
);

   localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_INSTR_BUSY, ST_DATA_BUSY} state_t;

   state_t      r_state;
   logic        r_last_data;
   logic        r_withdrawn;
   logic [7:0]  r_count;
   logic        r_instr_ack, r_instr_err, r_data_ack, r_data_err;
   logic [31:0] r_instr_data, r_data_rd_data;
   logic        r_mem_cyc, r_mem_stb, r_mem_wr_en;
   logic [31:0] r_mem_addr, r_mem_wr_data;
   logic [3:0]  r_mem_wr_sel;

   logic w_idle, w_instr_pend, w_data_pend, w_grant_instr, w_grant_data;
   logic w_req_live, w_timeout, w_done, w_deliver;

   // A requester whose ack is on the wire this cycle is still holding its request; don't re-grant it.
   assign w_idle        = (r_state == ST_IDLE);
   assign w_instr_pend  = instr_req & ~r_instr_ack;
   assign w_data_pend   = data_cyc & data_stb & ~r_data_ack;
   assign w_grant_data  = w_idle & w_data_pend & (~w_instr_pend | ~r_last_data);
   assign w_grant_instr = w_idle & w_instr_pend & (~w_data_pend | r_last_data);

   assign w_req_live = (r_state == ST_INSTR_BUSY) ? instr_req : data_cyc;
   assign w_timeout  = ~w_idle & ~mem_ack & (r_count == LP_TO_LAST);
   assign w_done     = ~w_idle & (mem_ack | w_timeout);
   assign w_deliver  = w_done & w_req_live & ~r_withdrawn;

   assign data_stall   = rst | ~w_grant_data;
   assign instr_ack    = r_instr_ack;
   assign instr_err    = r_instr_err;
   assign instr_data   = r_instr_data;
   assign data_ack     = r_data_ack;
   assign data_err     = r_data_err;
   assign data_rd_data = r_data_rd_data;
   assign mem_cyc      = r_mem_cyc;
   assign mem_stb      = r_mem_stb;
   assign mem_wr_en    = r_mem_wr_en;
   assign mem_addr     = r_mem_addr;
   assign mem_wr_data  = r_mem_wr_data;
   assign mem_wr_sel   = r_mem_wr_sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_last_data    <= 1'b0;
         r_withdrawn    <= 1'b0;
         r_count        <= '0;
         r_instr_ack    <= 1'b0;
         r_instr_err    <= 1'b0;
         r_data_ack     <= 1'b0;
         r_data_err     <= 1'b0;
         r_instr_data   <= '0;
         r_data_rd_data <= '0;
         r_mem_cyc      <= 1'b0;
         r_mem_stb      <= 1'b0;
         r_mem_wr_en    <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wr_data  <= '0;
         r_mem_wr_sel   <= '0;
      end else begin
         r_instr_ack <= 1'b0;
         r_instr_err <= 1'b0;
         r_data_ack  <= 1'b0;
         r_data_err  <= 1'b0;
         if (w_idle) begin
            r_count     <= '0;
            r_withdrawn <= 1'b0;
            if (w_grant_instr || w_grant_data) begin
               r_state       <= w_grant_data ? ST_DATA_BUSY : ST_INSTR_BUSY;
               r_last_data   <= w_grant_data;
               r_mem_cyc     <= 1'b1;
               r_mem_stb     <= 1'b1;
               r_mem_addr    <= w_grant_data ? data_addr : instr_addr;
               r_mem_wr_en   <= w_grant_data & data_wr_en;
               r_mem_wr_data <= w_grant_data ? data_wr_data : '0;
               r_mem_wr_sel  <= w_grant_data ? data_wr_sel : 4'hF;
            end
         end else begin
            r_count <= r_count + 8'd1;
            if (!w_req_live)
               r_withdrawn <= 1'b1;
            if (r_mem_stb && !mem_stall)
               r_mem_stb <= 1'b0;
            if (w_done) begin
               r_state   <= ST_IDLE;
               r_mem_cyc <= 1'b0;
               r_mem_stb <= 1'b0;
               if (w_deliver) begin
                  if (r_state == ST_INSTR_BUSY) begin
                     r_instr_ack  <= 1'b1;
                     r_instr_err  <= ~mem_ack;
                     r_instr_data <= mem_ack ? mem_rd_data : '0;
                  end else begin
                     r_data_ack     <= 1'b1;
                     r_data_err     <= ~mem_ack;
                     r_data_rd_data <= mem_ack ? mem_rd_data : '0;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed and randomized checks of memory_arbiter against a transaction-level model
module tb_memory_arbiter;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        instr_ack;
   logic [31:0] instr_data;
   logic        instr_err;
   logic        data_cyc, data_stb, data_wr_en;
   logic [31:0] data_addr, data_wr_data;
   logic [3:0]  data_wr_sel;
   logic        data_ack, data_err, data_stall;
   logic [31:0] data_rd_data;
   logic        mem_cyc, mem_stb, mem_wr_en;
   logic [31:0] mem_addr, mem_wr_data;
   logic [3:0]  mem_wr_sel;
   logic        mem_ack, mem_stall;
   logic [31:0] mem_rd_data;

   always #5 clk = ~clk;

   memory_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack),
      .instr_data(instr_data), .instr_err(instr_err),
      .data_cyc(data_cyc), .data_stb(data_stb), .data_wr_en(data_wr_en),
      .data_addr(data_addr), .data_wr_data(data_wr_data), .data_wr_sel(data_wr_sel),
      .data_ack(data_ack), .data_err(data_err), .data_stall(data_stall),
      .data_rd_data(data_rd_data),
      .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_wr_en(mem_wr_en),
      .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_sel(mem_wr_sel),
      .mem_ack(mem_ack), .mem_stall(mem_stall), .mem_rd_data(mem_rd_data)
   );

   int checks = 0;
   int errors = 0;

   int cfg_stall = 0;
   int cfg_lat   = 0;
   bit cfg_noack = 1'b0;
   bit cfg_spur  = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Memory slave: cfg_stall stall cycles, then cfg_lat idle cycles after acceptance, then ack.
   initial begin
      int stall_left;
      int wait_left;
      bit accepted;
      bit fresh;
      mem_ack = 1'b0; mem_stall = 1'b0; mem_rd_data = '0;
      stall_left = 0; wait_left = 0; accepted = 1'b0; fresh = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (!mem_cyc) begin
            mem_ack     = cfg_spur;
            mem_stall   = 1'b0;
            mem_rd_data = cfg_spur ? 32'hBAD0_BAD0 : 32'h0;
            accepted    = 1'b0;
            fresh       = 1'b1;
         end else begin
            if (fresh) begin
               stall_left = cfg_stall;
               wait_left  = cfg_lat;
               fresh      = 1'b0;
            end
            if (!accepted) begin
               mem_ack = 1'b0;
               if (stall_left > 0) begin
                  mem_stall = 1'b1;
                  stall_left--;
               end else begin
                  mem_stall = 1'b0;
                  accepted  = 1'b1;
               end
            end else begin
               mem_stall = 1'b0;
               if (cfg_noack) begin
                  mem_ack = 1'b0;
               end else if (wait_left > 0) begin
                  mem_ack = 1'b0;
                  wait_left--;
               end else begin
                  mem_ack     = 1'b1;
                  mem_rd_data = mem_word(mem_addr);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic wait_ack(input bit is_data, input string tag);
      int n;
      n = 0;
      while (!(is_data ? data_ack : instr_ack) && n < 60) begin
         step();
         n++;
      end
      chk1({tag, "_ack_seen"}, is_data ? data_ack : instr_ack, 1'b1);
   endtask

   initial begin
      int busy, ok, n, kind, exp_n, ai, grants, both_acks;
      bit granted_d, prev_cyc, model_last_data, dw;
      bit exp_who[2];
      logic [31:0] exp_addr[2];
      logic [31:0] ia, da, dd;
      logic [3:0] ds;

      rst = 1'b1; instr_req = 1'b0; instr_addr = '0;
      data_cyc = 1'b0; data_stb = 1'b0; data_wr_en = 1'b0;
      data_addr = '0; data_wr_data = '0; data_wr_sel = '0;
      repeat (3) step();
      chk1("rst_mem_cyc", mem_cyc, 1'b0);
      chk1("rst_mem_stb", mem_stb, 1'b0);
      chk1("rst_instr_ack", instr_ack, 1'b0);
      chk1("rst_data_ack", data_ack, 1'b0);
      chk1("rst_data_stall", data_stall, 1'b1);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      chk32("rst_instr_data", instr_data, 32'h0);
      chk32("rst_mem_wr_sel", 32'(mem_wr_sel), 32'h0);

      // Single fetch, memory acks one cycle after the strobe
      rst = 1'b0;
      instr_req = 1'b1; instr_addr = 32'h10;
      step();
      chk1("f_mem_cyc", mem_cyc, 1'b1);
      chk1("f_mem_stb", mem_stb, 1'b1);
      chk32("f_mem_addr", mem_addr, 32'h10);
      chk1("f_mem_wr_en", mem_wr_en, 1'b0);
      chk32("f_mem_wr_sel", 32'(mem_wr_sel), 32'hF);
      step();
      chk1("f_stb_one_cycle", mem_stb, 1'b0);
      chk1("f_ack_early", instr_ack, 1'b0);
      step();
      chk1("f_ack", instr_ack, 1'b1);
      chk1("f_err", instr_err, 1'b0);
      chk32("f_data", instr_data, mem_word(32'h10));
      step();
      chk1("f_no_regrant", mem_cyc, 1'b0);
      instr_req = 1'b0;
      chk1("f_ack_pulse", instr_ack, 1'b0);
      step();
      chk32("f_data_hold", instr_data, mem_word(32'h10));

      // Both pending after reset: data first, then instr
      rst = 1'b1; step(); rst = 1'b0;
      instr_req = 1'b1; instr_addr = 32'h100;
      data_cyc = 1'b1; data_stb = 1'b1; data_addr = 32'h200;
      #1 chk1("rr_grant_stall", data_stall, 1'b0);
      step();
      data_stb = 1'b0;
      #1;
      chk32("rr_first_addr", mem_addr, 32'h200);
      chk1("rr_busy_stall", data_stall, 1'b1);
      wait_ack(1'b1, "rr_data");
      chk32("rr_data_rd", data_rd_data, mem_word(32'h200));
      chk1("rr_data_err", data_err, 1'b0);
      chk1("rr_no_instr_ack", instr_ack, 1'b0);
      data_cyc = 1'b0;
      step();
      chk32("rr_second_addr", mem_addr, 32'h100);
      wait_ack(1'b0, "rr_instr");
      chk32("rr_instr_data", instr_data, mem_word(32'h100));
      instr_req = 1'b0;
      step();

      // Stalled write: strobe and bus values held while the slave stalls
      cfg_stall = 3;
      data_cyc = 1'b1; data_stb = 1'b1; data_wr_en = 1'b1;
      data_addr = 32'h20; data_wr_data = 32'hDEAD_BEEF; data_wr_sel = 4'b0011;
      step();
      data_stb = 1'b0; data_addr = 32'hFFFF_FFFF; data_wr_data = '0; data_wr_sel = '0;
      for (int i = 0; i < 4; i++) begin
         chk1("w_stb_held", mem_stb, 1'b1);
         chk32("w_addr", mem_addr, 32'h20);
         chk32("w_wr_data", mem_wr_data, 32'hDEAD_BEEF);
         chk32("w_wr_sel", 32'(mem_wr_sel), 32'h3);
         chk1("w_wr_en", mem_wr_en, 1'b1);
         step();
      end
      chk1("w_stb_drop", mem_stb, 1'b0);
      chk1("w_ack_early", data_ack, 1'b0);
      step();
      chk1("w_ack", data_ack, 1'b1);
      chk1("w_err", data_err, 1'b0);
      data_cyc = 1'b0; data_wr_en = 1'b0; cfg_stall = 0;
      step();
      chk1("w_single_ack", data_ack, 1'b0);

      // Memory never answers: abort after TO busy cycles
      cfg_noack = 1'b1;
      instr_req = 1'b1; instr_addr = 32'h30;
      step();
      busy = 0;
      for (int i = 0; i < TO; i++) begin
         if (mem_cyc && !instr_ack) busy++;
         step();
      end
      chk32("to_busy_cycles", busy, TO);
      chk1("to_ack", instr_ack, 1'b1);
      chk1("to_err", instr_err, 1'b1);
      chk32("to_data", instr_data, 32'h0);
      chk1("to_cyc_drop", mem_cyc, 1'b0);
      instr_req = 1'b0; cfg_noack = 1'b0;
      step();

      // Ack arrives in the last busy cycle: ack wins over timeout
      cfg_lat = TO - 2;
      instr_req = 1'b1; instr_addr = 32'h44;
      step();
      repeat (TO - 1) step();
      chk1("tie_ack_early", instr_ack, 1'b0);
      step();
      chk1("tie_ack", instr_ack, 1'b1);
      chk1("tie_err", instr_err, 1'b0);
      chk32("tie_data", instr_data, mem_word(32'h44));
      instr_req = 1'b0;
      step();

      // Fetch withdrawn after grant: no ack, data granted right after mem_ack
      cfg_lat = 3;
      instr_req = 1'b1; instr_addr = 32'h50;
      step();
      instr_req = 1'b0; data_addr = 32'h60;
      step();
      data_cyc = 1'b1; data_stb = 1'b1;
      ok = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (data_stall && !instr_ack) ok++;
         step();
      end
      chk32("fl_wait_cycles", ok, 4);
      chk1("fl_no_ack", instr_ack, 1'b0);
      chk1("fl_idle", mem_cyc, 1'b0);
      #1 chk1("fl_data_grant", data_stall, 1'b0);
      step();
      chk32("fl_data_addr", mem_addr, 32'h60);
      data_stb = 1'b0;
      wait_ack(1'b1, "fl_data");
      data_cyc = 1'b0; cfg_lat = 0;
      step();

      // Stray mem_ack while idle is ignored
      cfg_spur = 1'b1;
      repeat (3) step();
      chk1("sp_instr_ack", instr_ack, 1'b0);
      chk1("sp_data_ack", data_ack, 1'b0);
      chk1("sp_mem_cyc", mem_cyc, 1'b0);
      cfg_spur = 1'b0;
      repeat (2) step();

      // Reset during a data transaction
      cfg_noack = 1'b1;
      data_cyc = 1'b1; data_stb = 1'b1; data_addr = 32'h70;
      step();
      data_stb = 1'b0;
      step(); step();
      chk1("rb_busy", mem_cyc, 1'b1);
      rst = 1'b1; instr_req = 1'b1; instr_addr = 32'h80;
      step();
      chk1("rb_cyc_drop", mem_cyc, 1'b0);
      chk1("rb_no_ack", data_ack, 1'b0);
      data_stb = 1'b1; cfg_noack = 1'b0;
      #1 chk1("rb_stall_in_rst", data_stall, 1'b1);
      step();
      chk1("rb_no_ack2", data_ack, 1'b0);
      rst = 1'b0;
      #1 chk1("rb_data_grant", data_stall, 1'b0);
      step();
      chk32("rb_data_addr", mem_addr, 32'h70);
      data_stb = 1'b0;
      wait_ack(1'b1, "rb_data");
      data_cyc = 1'b0;
      wait_ack(1'b0, "rb_instr");
      chk32("rb_instr_data", instr_data, mem_word(32'h80));
      instr_req = 1'b0;
      step();

      // Randomized traffic against a transaction-level model
      rst = 1'b1; step(); rst = 1'b0;
      model_last_data = 1'b0;
      both_acks = 0;
      for (int it = 0; it < 40; it++) begin
         kind      = $urandom_range(0, 2);
         cfg_lat   = $urandom_range(0, 4);
         cfg_stall = $urandom_range(0, 2);
         cfg_noack = ($urandom_range(0, 9) == 0);
         ia = $urandom; da = $urandom; dd = $urandom; ds = 4'($urandom);
         dw = 1'($urandom_range(0, 1));
         exp_n = 0;
         if (kind == 2) begin
            exp_who[0] = ~model_last_data;
            exp_who[1] = model_last_data;
            exp_n = 2;
         end else begin
            exp_who[0] = (kind == 1);
            exp_n = 1;
         end
         for (int k = 0; k < exp_n; k++)
            exp_addr[k] = exp_who[k] ? da : ia;
         model_last_data = exp_who[exp_n - 1];

         instr_req = (kind != 1); instr_addr = ia;
         data_cyc = (kind != 0); data_stb = (kind != 0);
         data_addr = da; data_wr_en = dw; data_wr_data = dd; data_wr_sel = ds;
         ai = 0; grants = 0; n = 0; prev_cyc = 1'b0;
         while (ai < exp_n && n < 100) begin
            #1 granted_d = !data_stall;
            step();
            n++;
            if (granted_d) data_stb = 1'b0;
            if (mem_cyc && !prev_cyc) begin
               if (grants < exp_n) begin
                  chk32("rnd_grant_addr", mem_addr, exp_addr[grants]);
                  chk1("rnd_grant_wr_en", mem_wr_en, exp_who[grants] ? dw : 1'b0);
                  chk32("rnd_grant_wr_sel", 32'(mem_wr_sel), exp_who[grants] ? 32'(ds) : 32'hF);
               end
               grants++;
            end
            prev_cyc = mem_cyc;
            if (instr_ack && data_ack) both_acks++;
            if (instr_ack || data_ack) begin
               chk1("rnd_ack_who", data_ack, exp_who[ai]);
               if (data_ack) begin
                  chk1("rnd_data_err", data_err, cfg_noack);
                  chk32("rnd_data_rd", data_rd_data, cfg_noack ? 32'h0 : mem_word(exp_addr[ai]));
                  data_cyc = 1'b0; data_wr_en = 1'b0;
               end else begin
                  chk1("rnd_instr_err", instr_err, cfg_noack);
                  chk32("rnd_instr_data", instr_data, cfg_noack ? 32'h0 : mem_word(exp_addr[ai]));
                  instr_req = 1'b0;
               end
               ai++;
            end
         end
         chk32("rnd_acks_done", ai, exp_n);
         chk32("rnd_grant_count", grants, exp_n);
         instr_req = 1'b0; data_cyc = 1'b0; data_stb = 1'b0;
         step(); step();
      end
      chk32("rnd_no_double_ack", both_acks, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
